// File: rtl/synth_pkg.sv
// Shared synth definitions: tone divisors, sequencer state encoding and
// field-offset helpers for the packed score entry word.
package synth_pkg;

  // Tone divisors for the 16 MHz voice path: div = floor(62500 / f_note).
  localparam logic [10:0] tone_F1  = 11'd1431, tone_Fs1 = 11'd1351, tone_G1  = 11'd1275;
  localparam logic [10:0] tone_Gs1 = 11'd1203, tone_A1  = 11'd1136, tone_As1 = 11'd1072;
  localparam logic [10:0] tone_B1  = 11'd1012, tone_C2  = 11'd955,  tone_Cs2 = 11'd901;
  localparam logic [10:0] tone_D2  = 11'd851,  tone_Ds2 = 11'd803,  tone_E2  = 11'd758;
  localparam logic [10:0] tone_F2  = 11'd715,  tone_Fs2 = 11'd675,  tone_G2  = 11'd637;
  localparam logic [10:0] tone_Gs2 = 11'd601,  tone_A2  = 11'd568,  tone_As2 = 11'd536;
  localparam logic [10:0] tone_B2  = 11'd506,  tone_C3  = 11'd477,  tone_Cs3 = 11'd450;
  localparam logic [10:0] tone_D3  = 11'd425,  tone_Ds3 = 11'd401,  tone_E3  = 11'd379;
  localparam logic [10:0] tone_F3  = 11'd357,  tone_Fs3 = 11'd337,  tone_G3  = 11'd318;
  localparam logic [10:0] tone_Gs3 = 11'd300,  tone_A3  = 11'd284,  tone_As3 = 11'd268;
  localparam logic [10:0] tone_B3  = 11'd253,  tone_C4  = 11'd238,  tone_Cs4 = 11'd225;
  localparam logic [10:0] tone_D4  = 11'd212,  tone_Ds4 = 11'd200,  tone_E4  = 11'd189;
  localparam logic [10:0] tone_F4  = 11'd178,  tone_Fs4 = 11'd168,  tone_G4  = 11'd159;
  localparam logic [10:0] tone_Gs4 = 11'd150,  tone_A4  = 11'd142,  tone_As4 = 11'd134;
  localparam logic [10:0] tone_B4  = 11'd126,  tone_C5  = 11'd119,  tone_Cs5 = 11'd112;
  localparam logic [10:0] tone_D5  = 11'd106,  tone_Ds5 = 11'd100,  tone_E5  = 11'd94;
  localparam logic [10:0] tone_F5  = 11'd89,   tone_Fs5 = 11'd84,   tone_G5  = 11'd79;
  localparam logic [10:0] tone_Gs5 = 11'd75,   tone_A5  = 11'd71,   tone_As5 = 11'd67;
  localparam logic [10:0] tone_B5  = 11'd63,   tone_C6  = 11'd59,   tone_Cs6 = 11'd56;
  localparam logic [10:0] tone_D6  = 11'd53,   tone_Ds6 = 11'd50,   tone_E6  = 11'd47;
  localparam logic [10:0] tone_F6  = 11'd44,   tone_Fs6 = 11'd42,   tone_G6  = 11'd39;
  localparam logic [10:0] tone_Gs6 = 11'd37,   tone_A6  = 11'd35;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_PLAY  = 2'd3
  } seq_state_e;

  // Entry word: {eos, dur, ch[N-1]{oe,div} .. ch[0]{oe,div}}.
  function automatic int ch_lsb(input int n, input int div_w);
    return n * (div_w + 1);
  endfunction

  function automatic int dur_lsb(input int channels, input int div_w);
    return channels * (div_w + 1);
  endfunction

  function automatic int eos_bit(input int channels, input int dur_w, input int div_w);
    return dur_lsb(channels, div_w) + dur_w;
  endfunction

  function automatic int entry_w(input int channels, input int dur_w, input int div_w);
    return eos_bit(channels, dur_w, div_w) + 1;
  endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo tick generator: counts 0..T-1 with T = max(tick_div,1) and pulses
// tick on the last count. The >= compare lets a lowered tick_div take effect
// mid-count without wrapping through the whole counter range.
module tempo_tick #(
  parameter int TICK_W = 21
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              clear,
  input  logic [TICK_W-1:0] tick_div,
  output logic              tick
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] last_cnt;

  // Terminal count T-1, treating a zero divisor as one.
  always_comb begin
    last_cnt = (tick_div == '0) ? '0 : tick_div - TICK_W'(1);
    tick     = (cnt_q >= last_cnt);
  end

  // Tick counter; restarts on clear or after each tick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Table-driven multi-channel note sequencer. Steps through a score in an
// external synchronous ROM and drives per-channel gate and tone divisor.
module score_sequencer
  import synth_pkg::*;
#(
  parameter int               CHANNELS    = 2,
  parameter int               DIV_W       = 11,
  parameter int               DUR_W       = 8,
  parameter int               ADDR_W      = 8,
  parameter int               TICK_W      = 21,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = tone_C4
) (
  input  logic                                clk,
  input  logic                                nRST,
  input  logic                                start,
  input  logic                                stop,
  input  logic                                loop_en,
  input  logic [TICK_W-1:0]                   tick_div,
  output logic [ADDR_W-1:0]                   rom_addr,
  output logic                                rom_re,
  input  logic [1+DUR_W+CHANNELS*(1+DIV_W)-1:0] rom_data,
  output logic [CHANNELS-1:0]                 oe,
  output logic [CHANNELS*DIV_W-1:0]           div_num,
  output logic                                note_strobe,
  output logic                                busy,
  output logic                                done
);

  localparam int EOS_BIT = eos_bit(CHANNELS, DUR_W, DIV_W);
  localparam int DUR_LSB = dur_lsb(CHANNELS, DIV_W);

  seq_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         addr_d;
  logic [CHANNELS-1:0]       oe_d;
  logic [CHANNELS*DIV_W-1:0] div_d;
  logic [DUR_W-1:0]          dur_cnt, dur_d, entry_dur;
  logic                      entry_eos;
  logic                      strobe_d, done_d;
  logic                      tick_clear, tick;

  tempo_tick #(
    .TICK_W (TICK_W)
  ) u_tempo_tick (
    .clk      (clk),
    .nRST     (nRST),
    .clear    (tick_clear),
    .tick_div (tick_div),
    .tick     (tick)
  );

  // Next-state and next-output logic for the fetch/latch/play sequence.
  // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = rom_addr;
    oe_d       = oe;
    div_d      = div_num;
    dur_d      = dur_cnt;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    tick_clear = (state_q != ST_PLAY);
    entry_eos  = rom_data[EOS_BIT];
    entry_dur  = rom_data[DUR_LSB +: DUR_W];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (entry_eos) begin
          // An eos at address 0 always terminates, so looping can never spin on fetches.
          if (loop_en && (rom_addr != '0)) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            oe_d    = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          for (int n = 0; n < CHANNELS; n++) begin
            oe_d[n]                 = rom_data[ch_lsb(n, DIV_W) + DIV_W];
            div_d[n*DIV_W +: DIV_W] = rom_data[ch_lsb(n, DIV_W) +: DIV_W];
          end
          dur_d    = (entry_dur == '0) ? DUR_W'(1) : entry_dur;
          strobe_d = 1'b1;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (dur_cnt == DUR_W'(1)) begin
            addr_d  = rom_addr + ADDR_W'(1);
            state_d = ST_FETCH;
          end else begin
            dur_d = dur_cnt - DUR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stop overrides everything, including a simultaneous start; divisors are held.
    if (stop) begin
      state_d  = ST_IDLE;
      addr_d   = rom_addr;
      oe_d     = '0;
      div_d    = div_num;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      rom_addr    <= '0;
      rom_re      <= 1'b0;
      oe          <= '0;
      div_num     <= {CHANNELS{DEFAULT_DIV}};
      dur_cnt     <= '0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr    <= addr_d;
      rom_re      <= (state_d == ST_FETCH);
      oe          <= oe_d;
      div_num     <= div_d;
      dur_cnt     <= dur_d;
      note_strobe <= strobe_d;
      busy        <= (state_d != ST_IDLE);
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer with a behavioural synchronous score ROM.
module tb_score_sequencer;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [20:0] tick_div = 21'd4;
  logic [7:0]  rom_addr;
  logic        rom_re;
  logic [32:0] rom_data = '0;
  logic [1:0]  oe;
  logic [21:0] div_num;
  logic        note_strobe;
  logic        busy;
  logic        done;

  logic [32:0] rom [256];

  int n_checks = 0;
  int n_pass   = 0;

  int         strobe_at[$];
  logic [1:0] oe_at[$];
  int         div0_at[$];
  int         done_cnt, done_at, oe_hi_cnt, cyc;
  bit         reached;

  score_sequencer dut (
    .clk         (clk),
    .nRST        (nRST),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .tick_div    (tick_div),
    .rom_addr    (rom_addr),
    .rom_re      (rom_re),
    .rom_data    (rom_data),
    .oe          (oe),
    .div_num     (div_num),
    .note_strobe (note_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after rom_re.
  always @(posedge clk) begin
    if (rom_re) rom_data <= rom[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [32:0] mk(input logic eos, input logic [7:0] dur,
                                     input logic oe1, input logic [10:0] d1,
                                     input logic oe0, input logic [10:0] d0);
    return {eos, dur, oe1, d1, oe0, d0};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(1'b1, 8'd0, 1'b0, 11'd0, 1'b0, 11'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Sample each falling edge until idle, or until stop_strobes strobes were seen.
  task automatic run(input string tag, input int max_cyc, input int stop_strobes);
    strobe_at.delete(); oe_at.delete(); div0_at.delete();
    done_cnt = 0; done_at = -1; oe_hi_cnt = 0; cyc = 0; reached = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (note_strobe) begin
        strobe_at.push_back(cyc);
        oe_at.push_back(oe);
        div0_at.push_back(int'(div_num[10:0]));
      end
      if (done) begin done_cnt++; done_at = cyc; end
      if (oe != 2'b00) oe_hi_cnt++;
      reached = !busy || (stop_strobes > 0 && strobe_at.size() == stop_strobes);
    end while (!reached && cyc < max_cyc);
    check({tag, "_reached"}, reached, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oe"}, oe, 0);
    check({tag, "_div"}, div_num, {11'd238, 11'd238});
    check({tag, "_busy"}, busy, 0);
    check({tag, "_re"}, rom_re, 0);
    check({tag, "_addr"}, rom_addr, 0);
    check({tag, "_strobe"}, note_strobe, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    clear_rom();
    #12;
    check_reset_outputs("rst");
    @(negedge clk) nRST = 1'b1;

    // Single note: dur 3 at T=4 holds 3*4+2 cycles.
    rom[0] = mk(0, 8'd3, 0, 11'd0, 1, 11'd238);
    tick_div = 21'd4;
    pulse_start();
    run("single", 200, 0);
    check("single_oe_cycles", oe_hi_cnt, 14);
    check("single_strobes", strobe_at.size(), 1);
    if (strobe_at.size() == 1) begin
      check("single_oe_val", oe_at[0], 2'b01);
      check("single_div0", div0_at[0], 238);
    end
    check("single_done", done_cnt, 1);
    check("single_oe_after", oe, 0);
    check("single_div_after", div_num, {11'd0, 11'd238});

    // Rest and change at T=2.
    clear_rom();
    rom[0] = mk(0, 8'd2, 0, 11'd0, 1, 11'd189);
    rom[1] = mk(0, 8'd1, 0, 11'd0, 0, 11'd189);
    rom[2] = mk(0, 8'd1, 0, 11'd0, 1, 11'd158);
    tick_div = 21'd2;
    pulse_start();
    run("rest", 200, 0);
    check("rest_strobes", strobe_at.size(), 3);
    if (strobe_at.size() == 3) begin
      check("rest_oe0", oe_at[0], 2'b01);
      check("rest_oe1", oe_at[1], 2'b00);
      check("rest_oe2", oe_at[2], 2'b01);
      check("rest_div2", div0_at[2], 158);
      check("rest_gap01", strobe_at[1] - strobe_at[0], 6);
      check("rest_gap12", strobe_at[2] - strobe_at[1], 4);
      check("rest_gap2d", done_at - strobe_at[2], 4);
    end
    check("rest_done", done_cnt, 1);

    // Loop back to address 0, then disable looping mid-playback.
    loop_en = 1'b1;
    pulse_start();
    run("loop", 200, 4);
    check("loop_strobes", strobe_at.size(), 4);
    if (strobe_at.size() == 4) begin
      check("loop_div_reload", div0_at[3], 189);
      check("loop_gap", strobe_at[3] - strobe_at[2], 6);
    end
    check("loop_addr", rom_addr, 0);
    check("loop_no_done", done_cnt, 0);
    loop_en = 1'b0;
    run("loop_end", 200, 0);
    check("loop_end_strobes", strobe_at.size(), 2);
    check("loop_end_done", done_cnt, 1);
    check("loop_end_busy", busy, 0);

    // Stop mid-note.
    clear_rom();
    rom[0] = mk(0, 8'd3, 0, 11'd0, 1, 11'd300);
    tick_div = 21'd4;
    pulse_start();
    run("stop_pre", 100, 1);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("stop_oe", oe, 0);
    check("stop_busy", busy, 0);
    check("stop_re", rom_re, 0);
    check("stop_div_held", div_num[10:0], 300);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("stop_no_done", done_cnt, 0);

    // Stop and start together from idle: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("ss_busy", busy, 0);
    check("ss_re", rom_re, 0);
    @(negedge clk);
    check("ss_busy2", busy, 0);

    // dur = 0 acts as 1.
    rom[0] = mk(0, 8'd0, 0, 11'd0, 1, 11'd100);
    tick_div = 21'd4;
    pulse_start();
    run("dur0", 100, 0);
    check("dur0_cycles", oe_hi_cnt, 6);

    // tick_div = 0 acts as 1.
    rom[0] = mk(0, 8'd3, 0, 11'd0, 1, 11'd100);
    tick_div = 21'd0;
    pulse_start();
    run("tdiv0", 100, 0);
    check("tdiv0_cycles", oe_hi_cnt, 5);

    // eos at address 0 terminates even with looping enabled.
    rom[0] = mk(1, 8'd0, 0, 11'd0, 0, 11'd0);
    loop_en = 1'b1;
    pulse_start();
    run("eos0", 20, 0);
    check("eos0_done", done_cnt, 1);
    check("eos0_strobes", strobe_at.size(), 0);
    check("eos0_cycles", cyc, 2);
    loop_en = 1'b0;

    // Address wrap: 256 non-eos entries play straight through back to 0.
    for (int i = 0; i < 256; i++) rom[i] = mk(0, 8'd1, 0, 11'd0, 1, 11'(i + 1));
    tick_div = 21'd1;
    pulse_start();
    run("wrap", 1500, 257);
    check("wrap_strobes", strobe_at.size(), 257);
    if (strobe_at.size() == 257) begin
      check("wrap_div255", div0_at[255], 256);
      check("wrap_div0", div0_at[256], 1);
      check("wrap_gap", strobe_at[256] - strobe_at[255], 3);
    end
    check("wrap_addr", rom_addr, 0);
    check("wrap_no_done", done_cnt, 0);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;

    // Asynchronous reset during PLAY.
    clear_rom();
    rom[0] = mk(0, 8'd10, 1, 11'd500, 1, 11'd189);
    tick_div = 21'd4;
    pulse_start();
    run("arst_pre", 100, 1);
    check("arst_pre_oe", oe, 2'b11);
    @(negedge clk);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk) nRST = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
